// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared AES-128 constants and byte-level helper functions
//
// Purpose: the FSM state type, the forward S-box, the round constants and the
// byte/word helpers used by the encrypt round and the on-the-fly key schedule.
//
// Byte order: a 128-bit block holds byte i in bits [127-8*i -: 8], so byte 0 is
// bits [127:120]. Bytes are column-major: state[row][col] = byte[row + 4*col].
// A 32-bit word holds one column, with the row-0 byte in bits [31:24].
//
// Ports: none (package).

package aes128_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_e;

  // Forward S-box, element 0 first.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for rounds 1..10; any other counter value yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes128_enc_round.sv
// rtl/aes128_enc_round.sv - one combinational AES-128 encryption round
//
// Purpose: SubBytes, ShiftRows, MixColumns (skipped on the final round) and
// AddRoundKey applied to a 128-bit state.
//
// Ports:
//   state_i        128  state entering the round
//   round_key_i    128  key added at the end of the round
//   final_round_i    1  1 = bypass MixColumns (round 10)
//   state_o        128  state leaving the round

module aes128_enc_round
  import aes128_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         final_round_i,
  output logic [127:0] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_i[127-8*i -: 8]);
  end

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    // 3*a is expressed as xtime(a) ^ a.
    assign mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign state_o[127-8*i -: 8] = (final_round_i ? sr[i] : mc[i]) ^ round_key_i[127-8*i -: 8];
  end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption, one round per clock
//
// Purpose: encrypts one 128-bit block in 10 clocks after the accepting edge,
// expanding the key schedule one round key at a time so only the current
// state and current round key are held.
//
// Ports:
//   CLK            1  rising-edge clock
//   RST_N          1  asynchronous active-low reset
//   encEnable      1  start request, sampled only while idle
//   dataToOperate 128 plaintext block (byte 0 in [127:120])
//   keyToOperate  128 cipher key (same byte order)
//   busy           1  high while a block is in flight
//   opComplete     1  one-cycle pulse when opRetValue is updated
//   opRetValue    128 ciphertext, held until the next completion

module aes128_encrypt_iter
  import aes128_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         encEnable,
  input  logic [127:0] dataToOperate,
  input  logic [127:0] keyToOperate,
  output logic         busy,
  output logic         opComplete,
  output logic [127:0] opRetValue
);

  localparam logic [3:0] LAST_ROUND = 4'd10;

  enc_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] round_key_q, round_key_d;
  logic [127:0] result_q, result_d;
  logic [3:0]   round_q, round_d;
  logic         complete_q, complete_d;

  logic [31:0]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [127:0] next_key;
  logic [127:0] round_out;
  logic         final_round;
  logic         round_valid;

  // Next round key from the current one, using this round's constant.
  assign w0 = round_key_q[127:96];
  assign w1 = round_key_q[95:64];
  assign w2 = round_key_q[63:32];
  assign w3 = round_key_q[31:0];
  assign w4 = w0 ^ sub_word(rot_word(w3)) ^ {rcon(round_q), 24'h000000};
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  assign final_round = (round_q == LAST_ROUND);
  // Counter values 0 and 11..15 cannot occur in RUN; treat them as a fault.
  assign round_valid = (round_q != 4'd0) && (round_q <= LAST_ROUND);

  aes128_enc_round u_round (
    .state_i       (state_q),
    .round_key_i   (next_key),
    .final_round_i (final_round),
    .state_o       (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_key_d = round_key_q;
    round_d     = round_q;
    result_d    = result_q;
    complete_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (encEnable) begin
          state_d     = dataToOperate ^ keyToOperate;
          round_key_d = keyToOperate;
          round_d     = 4'd1;
          fsm_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!round_valid) begin
          round_d = 4'd0;
          fsm_d   = ST_IDLE;
        end else begin
          state_d     = round_out;
          round_key_d = next_key;
          round_d     = round_q + 4'd1;
          if (final_round) begin
            result_d   = round_out;
            complete_d = 1'b1;
            round_d    = 4'd0;
            fsm_d      = ST_IDLE;
          end
        end
      end
      default: begin
        round_d = 4'd0;
        fsm_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_key_q <= '0;
      round_q     <= '0;
      result_q    <= '0;
      complete_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_q     <= round_d;
      result_q    <= result_d;
      complete_q  <= complete_d;
    end
  end

  assign busy       = (fsm_q == ST_RUN);
  assign opComplete = complete_q;
  assign opRetValue = result_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - self-checking bench for aes128_encrypt_iter

module tb_aes128_encrypt_iter;

  logic         CLK;
  logic         RST_N;
  logic         encEnable;
  logic [127:0] dataToOperate;
  logic [127:0] keyToOperate;
  logic         busy;
  logic         opComplete;
  logic [127:0] opRetValue;

  int errors;
  int checks;

  aes128_encrypt_iter dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .encEnable     (encEnable),
    .dataToOperate (dataToOperate),
    .keyToOperate  (keyToOperate),
    .busy          (busy),
    .opComplete    (opComplete),
    .opRetValue    (opRetValue)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic         chk_r1;
    logic [127:0] r1;
  } vec_t;

  vec_t vecs [3];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits up to 20 cycles for opComplete; n counts clocks since the accepting edge.
  task automatic wait_complete(input string name, input logic chk_r1, input logic [127:0] r1,
                               inout int n);
    while (!opComplete && n < 20) begin
      @(negedge CLK);
      n++;
      if (chk_r1 && n == 1) check({name, " round1 state"}, dut.state_q, r1);
    end
  endtask

  task automatic count_pulses(input int ncyc, output int npulse);
    npulse = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK);
      if (opComplete) npulse++;
    end
  endtask

  task automatic run_block(input string name, input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input logic chk_r1, input logic [127:0] r1);
    int n;
    @(negedge CLK);
    keyToOperate  = key;
    dataToOperate = pt;
    encEnable     = 1'b1;
    @(negedge CLK);
    encEnable = 1'b0;
    n = 0;
    check({name, " busy"}, 128'(busy), 128'(1));
    wait_complete(name, chk_r1, r1, n);
    check({name, " latency"}, 128'(n), 128'(10));
    check({name, " ciphertext"}, opRetValue, ct);
    @(negedge CLK);
    check({name, " pulse width"}, 128'(opComplete), 128'(0));
    check({name, " busy after"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int m;
    int p;
    logic hold_ok;

    errors = 0;
    checks = 0;
    vecs[0] = '{"c1",    C1_KEY, C1_PT, C1_CT, 1'b0, 128'h0};
    vecs[1] = '{"appB",  B_KEY,  B_PT,  B_CT,  1'b1, B_R1};
    vecs[2] = '{"zeros", 128'h0, 128'h0, Z_CT, 1'b0, 128'h0};

    RST_N         = 1'b0;
    encEnable     = 1'b0;
    dataToOperate = '0;
    keyToOperate  = '0;
    repeat (3) @(negedge CLK);
    check("reset busy", 128'(busy), 128'(0));
    check("reset opComplete", 128'(opComplete), 128'(0));
    check("reset opRetValue", opRetValue, 128'h0);
    RST_N = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_block(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].chk_r1, vecs[i].r1);
    end

    // Start request and input change while busy must be ignored.
    @(negedge CLK);
    keyToOperate  = '0;
    dataToOperate = '0;
    encEnable     = 1'b1;
    @(negedge CLK);
    encEnable = 1'b0;
    n = 0;
    @(negedge CLK);
    @(negedge CLK);
    n = 2;
    encEnable     = 1'b1;
    keyToOperate  = C1_KEY;
    dataToOperate = C1_PT;
    @(negedge CLK);
    n = 3;
    encEnable = 1'b0;
    check("ignore busy", 128'(busy), 128'(1));
    wait_complete("ignore", 1'b0, 128'h0, n);
    check("ignore latency", 128'(n), 128'(10));
    check("ignore ciphertext", opRetValue, Z_CT);
    count_pulses(15, p);
    check("ignore extra pulses", 128'(p), 128'(0));
    check("ignore result held", opRetValue, Z_CT);

    // encEnable held high: back-to-back blocks 11 cycles apart.
    @(negedge CLK);
    keyToOperate  = C1_KEY;
    dataToOperate = C1_PT;
    encEnable     = 1'b1;
    @(negedge CLK);
    n = 0;
    keyToOperate  = B_KEY;
    dataToOperate = B_PT;
    wait_complete("b2b first", 1'b0, 128'h0, n);
    check("b2b first latency", 128'(n), 128'(10));
    check("b2b first ciphertext", opRetValue, C1_CT);
    m = 0;
    hold_ok = 1'b1;
    do begin
      @(negedge CLK);
      m++;
      if (m == 1) begin
        encEnable = 1'b0;
        check("b2b second busy", 128'(busy), 128'(1));
      end
      if (!opComplete && opRetValue !== C1_CT) hold_ok = 1'b0;
    end while (!opComplete && m < 30);
    check("b2b spacing", 128'(m), 128'(11));
    check("b2b second ciphertext", opRetValue, B_CT);
    check("b2b hold between", 128'(hold_ok), 128'(1));

    // Reset in round 5 aborts the block.
    @(negedge CLK);
    keyToOperate  = C1_KEY;
    dataToOperate = C1_PT;
    encEnable     = 1'b1;
    @(negedge CLK);
    encEnable = 1'b0;
    repeat (4) @(negedge CLK);
    check("abort round", 128'(dut.round_q), 128'(5));
    RST_N = 1'b0;
    #1;
    check("abort busy", 128'(busy), 128'(0));
    check("abort opComplete", 128'(opComplete), 128'(0));
    check("abort opRetValue", opRetValue, 128'h0);
    @(negedge CLK);
    @(negedge CLK);
    check("abort opRetValue in reset", opRetValue, 128'h0);
    RST_N = 1'b1;
    count_pulses(15, p);
    check("abort no completion", 128'(p), 128'(0));
    run_block("after reset", C1_KEY, C1_PT, C1_CT, 1'b0, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes128_encrypt_iter.md
Name: aes128_encrypt_iter

Overview:
Iterative AES-128 encryption core, the forward-direction counterpart of the team's AES-128 decrypt datapath. It computes one FIPS-197 round per clock, with on-the-fly key expansion, so only the current state and current round key are stored. It sits beside the decrypt block under the top-level crypto controller and uses a start/complete handshake with the same data/key port naming.

Parameters:
None. AES-128 only: 10 rounds, 128-bit key and block.

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  asynchronous active-low reset
encEnable  input  1  start request; sampled only in IDLE
dataToOperate  input  128  plaintext block, byte 0 = bits [127:120], FIPS-197 column-major
keyToOperate  input  128  cipher key, same byte order
busy  output  1  high while a block is in flight
opComplete  output  1  one-cycle pulse when opRetValue is updated
opRetValue  output  128  ciphertext; holds until the next completion

Behaviour:
- Reset (async assert, sync release):
  - state, roundKey, round counter and opRetValue clear to 0.
  - busy=0, opComplete=0, FSM returns to IDLE.
  - Reset mid-operation aborts the block with no completion pulse.
- FSM states: IDLE and RUN.
- IDLE, encEnable=1 at edge E0:
  - state <= dataToOperate ^ keyToOperate (AddRoundKey with K0).
  - roundKey <= keyToOperate; round <= 1; busy <= 1; go to RUN.
- RUN, edges E1..E9 (round 1..9):
  - nextKey = KeyExpandStep(roundKey, RCON[round]).
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ nextKey.
  - roundKey <= nextKey; round <= round+1.
- RUN, edge E10 (round 10, final):
  - Same as E1..E9 but MixColumns is bypassed.
  - opRetValue <= result; opComplete <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency: opComplete is seen high in the cycle after E10, 10 clocks after the accepting edge. Minimum start-to-start interval is 11 clocks; a new start is accepted at E11 at the earliest.
- encEnable while busy=1 is ignored. Inputs are not re-sampled mid-block, so dataToOperate and keyToOperate may change freely after E0.
- encEnable held high continuously: a new block is accepted at each IDLE edge, i.e. back-to-back blocks every 11 cycles.
- KeyExpandStep: w4 = w0 ^ SubWord(RotWord(w3)) ^ {RCON,24'h0}, followed by the standard word chaining.
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
- Round counter: 4 bits; values 11..15 are unreachable and force IDLE if ever reached.

Decomposition:
- Package aes128_pkg:
  - 256-entry SBOX constant and RCON[1..10] constant.
  - Byte-order convention.
  - Functions xtime, SubWord, RotWord.
- One combinational sub-module, aes128_enc_round:
  - Inputs: state, round key, finalRound flag.
  - Applies SubBytes, ShiftRows, MixColumns (bypassed when finalRound=1), then AddRoundKey.
  - Contains 16 S-box lookups.
- Key expansion step is implemented inline in the top module using the package SubWord.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> opRetValue 69c4e0d86a7b0430d8cdb78070b4c55a. opComplete high for exactly 1 cycle, 10 clocks after the accepting edge.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check the round-1 internal state against the appendix (a49c7ff2689f352b6b5bea43026a5049).
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
  - Then pulse encEnable and change inputs at E3 while busy.
  - Result is unchanged and no second opComplete occurs.
- encEnable held high with C.1 then App. B vectors: two completions exactly 11 cycles apart with correct ciphertexts; opRetValue holds C.1's result between the pulses.
- Assert RST_N=0 at round 5, release, start the C.1 vector:
  - No completion for the aborted block.
  - Outputs read 0 during reset.
  - The new block completes correctly.
